// File: rtl/skew_feeder_pkg.sv
// Shared definitions for the systolic edge feeder: FSM state encoding and
// drain-length helper.
package skew_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Skew lines empty in lanes-1 cycles, then the wavefront crosses the array in lanes more.
  function automatic int flush_cycles(input int lanes);
    return (32'sd2 * lanes) - 32'sd1;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Fixed-depth register chain that delays one operand lane; cleared by a
// synchronous active-high reset.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift chain: stage 0 captures the input, later stages follow.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_r[s] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_r[0] <= d;
      for (int s = 1; s < DEPTH; s++) begin
        stage_r[s] <= stage_r[s-1];
      end
    end
  end

  assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/skew_feeder.sv
// Edge feeder for a LANES x LANES systolic MAC array: accepts operand beats,
// skews lane i by i cycles, zero-fills bubbles and the drain tail, pulses done.
module skew_feeder
  import skew_feeder_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int KW    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES*WIDTH-1:0] lane_out,
  output logic                   busy,
  output logic                   done
);

  localparam int FLUSH_CYC = flush_cycles(LANES);
  localparam int FW        = $clog2(FLUSH_CYC);

  state_t                 state_r;
  state_t                 state_s;
  logic [KW-1:0]          k_len_r;
  logic [KW-1:0]          beat_cnt_r;
  logic [FW-1:0]          flush_cnt_r;
  logic                   accept_s;
  logic                   last_beat_s;
  logic                   flush_end_s;
  logic [LANES*WIDTH-1:0] feed_s;
  logic                   in_ready_s;
  logic                   busy_s;
  logic                   done_s;
  logic                   in_ready_r;
  logic                   busy_r;
  logic                   done_r;

  assign accept_s    = in_valid & in_ready_r;
  assign last_beat_s = accept_s & (beat_cnt_r == (k_len_r - KW'(1)));
  assign flush_end_s = (flush_cnt_r == FW'(FLUSH_CYC - 1));
  // Bubbles and every non-streaming cycle push zeros, which add nothing to the MACs.
  assign feed_s      = accept_s ? in_data : {(LANES*WIDTH){1'b0}};

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = (k_len != KW'(0)) ? ST_STREAM : ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (last_beat_s) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_FLUSH: begin
        if (flush_end_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Beat and flush counters plus the latched transfer length.
  always_ff @(posedge clock) begin
    if (reset) begin
      k_len_r     <= KW'(0);
      beat_cnt_r  <= KW'(0);
      flush_cnt_r <= FW'(0);
    end else begin
      if ((state_r == ST_IDLE) && start) begin
        k_len_r    <= k_len;
        beat_cnt_r <= KW'(0);
      end else if (accept_s) begin
        beat_cnt_r <= beat_cnt_r + KW'(1);
      end
      flush_cnt_r <= (state_r == ST_FLUSH) ? (flush_cnt_r + FW'(1)) : FW'(0);
    end
  end

  // Output decode; in_ready follows the upcoming state so it is high in every STREAM cycle.
  always_comb begin
    in_ready_s = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    if (state_s == ST_STREAM) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    busy_s = (state_r != ST_IDLE);
    done_s = (state_r == ST_DONE);
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      in_ready_r <= in_ready_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign in_ready = in_ready_r;
  assign busy     = busy_r;
  assign done     = done_r;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    skew_line #(
      .DEPTH(i + 1),
      .WIDTH(WIDTH)
    ) u_line (
      .clock(clock),
      .reset(reset),
      .d    (feed_s[i*WIDTH +: WIDTH]),
      .q    (lane_out[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_skew_feeder.sv
// Self-checking bench for skew_feeder: directed vector table, multi-cycle
// corner sequences and randomized traffic against a beat-history model.
module tb_skew_feeder;

  localparam int L   = 4;
  localparam int W   = 8;
  localparam int KW  = 8;
  localparam int BIG = 1 << 30;

  logic              clock;
  logic              reset;
  logic              start;
  logic [KW-1:0]     k_len;
  logic              in_valid;
  logic              in_ready;
  logic [L*W-1:0]    in_data;
  logic [L*W-1:0]    lane_out;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;

  skew_feeder #(.LANES(L), .WIDTH(W), .KW(KW)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .k_len   (k_len),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .lane_out(lane_out),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: which edge accepted which beat, and the transfer window.
  int             edge_n = 0;
  logic [L*W-1:0] acc_hist [int];
  bit             m_active;
  int             m_k;
  int             m_nacc;
  int             m_busy_from;
  int             m_done_edge;

  task automatic model_reset();
    m_active    = 1'b0;
    m_k         = 0;
    m_nacc      = 0;
    m_busy_from = BIG;
    m_done_edge = -1;
    acc_hist.delete();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare.
  task automatic step();
    logic [L*W-1:0] exp_lane;
    logic [L*W-1:0] beat;
    bit             take;
    take = m_active && (m_nacc < m_k) && (in_valid === 1'b1);
    @(posedge clock);
    edge_n++;
    if (reset) begin
      model_reset();
    end else if (take) begin
      acc_hist[edge_n] = in_data;
      m_nacc++;
      if (m_nacc == m_k) m_done_edge = edge_n + 2 * L;
    end else if (!m_active && start) begin
      m_active    = 1'b1;
      m_k         = int'(k_len);
      m_nacc      = 0;
      m_busy_from = edge_n + 1;
      m_done_edge = (k_len == 8'd0) ? edge_n + 1 : BIG;
    end
    @(negedge clock);
    exp_lane = '0;
    for (int i = 0; i < L; i++) begin
      if (acc_hist.exists(edge_n - i)) begin
        beat = acc_hist[edge_n - i];
        exp_lane[i*W +: W] = beat[i*W +: W];
      end
    end
    chk("lane_out", lane_out, exp_lane);
    chk("in_ready", {31'd0, in_ready}, {31'd0, (m_active && (m_nacc < m_k))});
    chk("busy", {31'd0, busy}, {31'd0, ((edge_n >= m_busy_from) && (edge_n <= m_done_edge))});
    chk("done", {31'd0, done}, {31'd0, (edge_n == m_done_edge)});
    if (m_active && (edge_n >= m_done_edge)) m_active = 1'b0;
  endtask

  typedef struct {
    logic           start;
    logic [KW-1:0]  k_len;
    logic           in_valid;
    logic [L*W-1:0] in_data;
    logic [L*W-1:0] exp_lane;
    logic           exp_ready;
    logic           exp_busy;
    logic           exp_done;
  } vec_t;

  vec_t tbl [13];

  logic [L*W-1:0] beats [3];
  int n;
  int dones;

  initial begin
    // Back-to-back k_len=3 transfer, one row per cycle.
    tbl[0]  = '{1'b1, 8'd3, 1'b0, 32'h0,          32'h0,          1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'd0, 1'b1, 32'h04030201,   32'h00000001,   1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'd0, 1'b1, 32'h08070605,   32'h00000205,   1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'd0, 1'b1, 32'h0C0B0A09,   32'h00030609,   1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'd0, 1'b0, 32'h0,          32'h04070A00,   1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'd0, 1'b0, 32'h0,          32'h080B0000,   1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 8'd0, 1'b0, 32'h0,          32'h0C000000,   1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 8'd0, 1'b0, 32'h0,          32'h0,          1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'd0, 1'b0, 32'h0,          32'h0,          1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'd0, 1'b0, 32'h0,          32'h0,          1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'd0, 1'b0, 32'h0,          32'h0,          1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'd0, 1'b0, 32'h0,          32'h0,          1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 8'd0, 1'b0, 32'h0,          32'h0,          1'b0, 1'b0, 1'b0};
    beats[0] = 32'h04030201;
    beats[1] = 32'h08070605;
    beats[2] = 32'h0C0B0A09;

    model_reset();
    reset = 1'b1; start = 1'b0; k_len = 8'd0; in_valid = 1'b1; in_data = 32'hDEADBEEF;

    // Reset held three cycles with live-looking input, then one released cycle.
    for (int c = 0; c < 3; c++) step();
    reset = 1'b0; in_valid = 1'b0;
    step();

    // Table-driven main transfer.
    for (int r = 0; r < 13; r++) begin
      start = tbl[r].start; k_len = tbl[r].k_len;
      in_valid = tbl[r].in_valid; in_data = tbl[r].in_data;
      step();
      chk("tbl_lane", lane_out, tbl[r].exp_lane);
      chk("tbl_ready", {31'd0, in_ready}, {31'd0, tbl[r].exp_ready});
      chk("tbl_busy", {31'd0, busy}, {31'd0, tbl[r].exp_busy});
      chk("tbl_done", {31'd0, done}, {31'd0, tbl[r].exp_done});
    end
    start = 1'b0; in_valid = 1'b0; in_data = '0;

    // Same transfer with two bubbles after beat 1: done moves 2 cycles later.
    start = 1'b1; k_len = 8'd3; step(); start = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = (c == 0) || (c == 3) || (c == 4);
      in_data  = (c == 0) ? beats[0] : ((c == 3) ? beats[1] : beats[2]);
      step();
      n++;
      if (done) break;
    end
    chk("bubble_done_latency", n, 13);
    in_valid = 1'b0; in_data = '0;
    step();

    // Zero-length transfer.
    start = 1'b1; k_len = 8'd0; in_valid = 1'b1; in_data = 32'h11223344;
    step();
    chk("k0_no_early_done", {31'd0, done}, 32'd0);
    start = 1'b0;
    step();
    chk("k0_done", {31'd0, done}, 32'd1);
    in_valid = 1'b0;
    step();

    // Reset after two of three beats aborts without done.
    start = 1'b1; k_len = 8'd3; step(); start = 1'b0;
    in_valid = 1'b1; in_data = beats[0]; step();
    in_data = beats[1]; step();
    in_data = beats[2]; reset = 1'b1; step();
    reset = 1'b0; in_valid = 1'b0;
    chk("abort_lane", lane_out, 32'h0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    start = 1'b1; k_len = 8'd1; step(); start = 1'b0;
    in_valid = 1'b1; in_data = 32'h07070707; step();
    in_valid = 1'b0; in_data = '0;
    for (int c = 0; c < 12; c++) step();

    // start held high through STREAM and FLUSH is ignored.
    start = 1'b1; k_len = 8'd2; step();
    k_len = 8'd5; dones = 0; n = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = (c < 2); in_data = beats[c % 3];
      step();
      n++;
      if (done) begin dones++; break; end
    end
    start = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin step(); if (done) dones++; end
    chk("start_ignored_latency", n, 10);
    chk("start_ignored_dones", dones, 1);

    // Longest transfer: 255 beats without counter wrap.
    start = 1'b1; k_len = 8'd255; step(); start = 1'b0;
    n = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'b1; in_data = $urandom;
      step();
      n++;
      if (done) break;
    end
    chk("k255_done_latency", n, 263);
    in_valid = 1'b0;
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 149) == 0);
      start    = ($urandom_range(0, 7) == 0);
      k_len    = 8'($urandom_range(0, 6));
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = $urandom;
      step();
    end
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 20; c++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/skew_feeder.md
Name: skew_feeder

Overview:
Edge feeder that transmits operand streams into one edge of the systolic array of MAC elements.
- Accepts one LANES-wide operand vector per beat via valid/ready.
- Delays lane i by i extra cycles, producing the diagonal wavefront the elements expect.
- Inserts zeros for bubbles and for the drain tail.
- Pulses done once the last operand has propagated through a LANES x LANES array.

Parameters:
LANES, 4, number of array rows/columns fed (lanes); must be >= 2
WIDTH, 8, operand width per lane, matching element a/b width
KW, 8, width of the beat-count input k_len

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high; clears all state on the clock edge where it is high
start  input  1  begin a transfer; sampled only in IDLE
k_len  input  KW  number of beats in the transfer; latched on accepted start
in_valid  input  1  in_data holds a beat
in_ready  output  1  feeder accepts a beat this cycle
in_data  input  LANES*WIDTH  lane i = bits [i*WIDTH +: WIDTH]
lane_out  output  LANES*WIDTH  skewed operands to array edge, same lane packing
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at end of transfer

Behaviour:
- Reset values: state IDLE; lane_out = 0; in_ready = 0; busy = 0; done = 0; beat and flush counters = 0; every skew register = 0.
- Reset mid-transfer aborts it. Outputs are 0 in the cycle after the reset edge. The partial transfer is discarded with no done.
- States: IDLE, STREAM, FLUSH, DONE.
- IDLE:
  - start=1 with k_len != 0: latch k_len, go to STREAM.
  - start=1 with k_len == 0: go to DONE.
  - Skew lines are fed zeros.
- STREAM:
  - in_ready = 1 (registered state decode, not combinational on in_valid).
  - Accept = in_valid & in_ready.
  - On accept, in_data enters the skew lines and the beat counter increments.
  - With no accept (bubble), all-zero is entered in every lane and the counter is unchanged. Zero operands contribute nothing to the accumulation.
  - Accept of beat k_len goes to FLUSH.
- FLUSH:
  - in_ready = 0; zeros are fed.
  - Lasts exactly 2*LANES-1 cycles: LANES-1 cycles to empty the skew lines, plus LANES cycles of array propagation and MAC.
  - Then go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- start is ignored in any state other than IDLE.
- Skew timing: a beat accepted on edge E appears on lane_out lane i during the cycle after edge E+i. Lane 0 latency is 1 cycle; lane i latency is 1+i. Each lane is a pure register chain with no arithmetic.
- done timing: done is high in the cycle after edge F+2*LANES, where F is the edge accepting the final beat.
- Counters: the beat counter is KW bits and compares against latched k_len. The maximum transfer of 2^KW-1 beats does not wrap. The flush counter is sized for 2*LANES-1.

Decomposition:
- Shared package skew_feeder_pkg:
  - state encoding (IDLE, STREAM, FLUSH, DONE, 2 bits);
  - function flush_cycles(LANES) = 2*LANES-1.
- Sub-module skew_line:
  - parameters DEPTH and WIDTH; DEPTH-stage register chain with synchronous active-high reset to 0.
  - Instantiated LANES times via generate, with DEPTH = i+1 for lane i.
- The top level holds the FSM, counters and the zero-insertion mux.

Test Plan (LANES=4, WIDTH=8):
- Reset held 3 cycles with in_valid=1 and in_data nonzero -> lane_out=0, in_ready=0, busy=0, done=0 throughout and one cycle after.
- start, k_len=3; beats {1,2,3,4}, {5,6,7,8}, {9,10,11,12} back-to-back (lane0 listed first) -> lane0 shows 1,5,9 then 0; lane3 shows 0,0,0,4,8,12 then 0; done pulses once, 8 cycles after the third accept edge; busy falls with it.
- Same transfer with in_valid low for 2 cycles between beats 1 and 2 -> two all-zero slots on every lane, skewed by lane; still exactly 3 beats accepted; done shifts later by 2 cycles.
- start with k_len=0 -> done high in the cycle after the next edge; in_ready never 1; lane_out stays 0.
- Reset asserted after 2 of 3 beats -> lane_out all 0 and state IDLE after the reset edge; no done. A following start with k_len=1 and beat {7,7,7,7} -> lane i shows 7 after 1+i cycles; done follows normally.
- start pulsed during STREAM and FLUSH -> no effect on the beat count or done timing; exactly one done per transfer.
